// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default payload width and line levels.
// Imported by both the transmit and receive sides.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/tx_serializer.sv
// Payload shift register, bit counter and parity generator for uart_tx.
// ser_bit is the next payload bit to be placed on the line; the top registers it.
module tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_par_typ,
    input  logic                  shift,
    input  logic                  count,
    output logic                  ser_bit,
    output logic                  last_bit,
    output logic                  par_bit
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;

    // Payload and parity are pure data; only the counter needs a defined reset value.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg   <= load_data;
            par_bit <= (^load_data) ^ load_par_typ;
        end else if (shift) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
        end else if (load) begin
            bit_cnt <= '0;
        end else if (count) begin
            bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    assign ser_bit  = shreg[0];
    assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FSM, registered serial output and optional one-word holding buffer.
// Define UART_TX_HOLD_BUF_EN to compile in the holding buffer for back-to-back frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  ready
);
    tx_state_t             state, state_nxt;
    logic                  tx_out_nxt;
    logic                  accept, launch;
    logic [DATA_WIDTH-1:0] launch_data;
    logic                  launch_par_en, launch_par_typ;
    logic                  par_en_q;
    logic                  ser_bit, last_bit, par_bit;

`ifdef UART_TX_HOLD_BUF_EN
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_par_en, hold_par_typ, hold_full;

    assign ready  = !hold_full;
    assign accept = DATA_VALID && ready;
    // A new frame may start from IDLE or straight out of STOP; a buffered word has priority.
    assign launch         = ((state == IDLE) || (state == STOP)) && (hold_full || accept);
    assign launch_data    = hold_full ? hold_data    : P_DATA;
    assign launch_par_en  = hold_full ? hold_par_en  : PAR_EN;
    assign launch_par_typ = hold_full ? hold_par_typ : PAR_TYP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full <= 1'b0;
        end else if (launch && hold_full) begin
            hold_full <= 1'b0;
        end else if (accept && !launch) begin
            hold_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !launch) begin
            hold_data    <= P_DATA;
            hold_par_en  <= PAR_EN;
            hold_par_typ <= PAR_TYP;
        end
    end
`else
    assign ready          = (state == IDLE);
    assign accept         = DATA_VALID && ready;
    assign launch         = accept;
    assign launch_data    = P_DATA;
    assign launch_par_en  = PAR_EN;
    assign launch_par_typ = PAR_TYP;
`endif

    tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load        (launch),
        .load_data   (launch_data),
        .load_par_typ(launch_par_typ),
        .shift       ((state == START) || (state == DATA)),
        .count       (state == DATA),
        .ser_bit     (ser_bit),
        .last_bit    (last_bit),
        .par_bit     (par_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_q <= 1'b0;
        end else if (launch) begin
            par_en_q <= launch_par_en;
        end
    end

    // tx_out_nxt is the level of the state being entered, so TX_OUT tracks state exactly.
    always_comb begin
        state_nxt  = state;
        tx_out_nxt = IDLE_LVL;
        case (state)
            IDLE: begin
                if (launch) begin
                    state_nxt  = START;
                    tx_out_nxt = START_LVL;
                end
            end
            START: begin
                state_nxt  = DATA;
                tx_out_nxt = ser_bit;
            end
            DATA: begin
                tx_out_nxt = ser_bit;
                if (last_bit) begin
                    if (par_en_q) begin
                        state_nxt  = PARITY;
                        tx_out_nxt = par_bit;
                    end else begin
                        state_nxt  = STOP;
                        tx_out_nxt = STOP_LVL;
                    end
                end
            end
            PARITY: begin
                state_nxt  = STOP;
                tx_out_nxt = STOP_LVL;
            end
            STOP: begin
                if (launch) begin
                    state_nxt  = START;
                    tx_out_nxt = START_LVL;
                end else begin
                    state_nxt  = IDLE;
                    tx_out_nxt = IDLE_LVL;
                end
            end
            default: begin
                state_nxt  = IDLE;
                tx_out_nxt = IDLE_LVL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            TX_OUT <= IDLE_LVL;
        end else begin
            state  <= state_nxt;
            TX_OUT <= tx_out_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have port clk  input  1  bit-rate clock; one serial bit per clk cycle.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port P_DATA  input  DATA_WIDTH  parallel word to transmit.
REQ-005 SHALL have port DATA_VALID  input  1  P_DATA offered this cycle.
REQ-006 SHALL have port PAR_EN  input  1  1 = append parity bit.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port TX_OUT  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  frame on the line.
REQ-010 SHALL have port ready  output  1  word accepted when DATA_VALID and ready are both high.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE: TX_OUT=1, busy=0; an accept moves the FSM to START on the next edge.
REQ-013 SHALL latch P_DATA, PAR_EN and PAR_TYP at accept; later input changes SHALL not affect the frame in flight.
REQ-014 START: TX_OUT=0 for exactly 1 cycle, beginning the cycle after accept (latency 1).
REQ-015 DATA: DATA_WIDTH cycles, LSB first; a 3-bit bit counter (log2 DATA_WIDTH) wraps from 7 to 0 on exit.
REQ-016 PARITY: entered only if latched PAR_EN=1; 1 cycle; bit = XOR(data) for even, ~XOR(data) for odd.
REQ-017 STOP: TX_OUT=1 for 1 cycle; then IDLE, or START per REQ-025.
REQ-018 Frame length SHALL be 10 cycles (PAR_EN=0) or 11 cycles (PAR_EN=1) for DATA_WIDTH=8.
REQ-019 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-020 TX_OUT SHALL be registered, with no combinational path from any input.
REQ-021 DATA_VALID while ready=0 SHALL be ignored and the word dropped, with no effect on the current frame.

Reset
REQ-022 rst low SHALL immediately force TX_OUT=1, busy=0, ready=1, FSM=IDLE, counters=0 and the holding buffer empty.
REQ-023 Reset asserted mid-frame SHALL abort the frame; after release the line stays high until a new accept.

Configuration
REQ-024 Macro UART_TX_HOLD_BUF_EN SHALL select the buffering mode.
REQ-025 With UART_TX_HOLD_BUF_EN: a one-word holding register (data, PAR_EN, PAR_TYP) is compiled in; ready = holding register empty; accept while busy fills it; in STOP with the buffer full, the next state is START (back-to-back, no idle cycle) and the buffer empties.
REQ-026 With UART_TX_HOLD_BUF_EN: accept in the same cycle the buffer drains SHALL be refused, because ready is 0 that cycle.
REQ-027 Without UART_TX_HOLD_BUF_EN: no holding register; ready = (state==IDLE); frames are separated by at least 1 idle cycle.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state enum typedef, the DATA_WIDTH default, and the constants IDLE_LVL=1, START_LVL=0 and STOP_LVL=1.
REQ-029 The rx side SHALL import the same package for the line-level constants.
REQ-030 Sub-module tx_serializer SHALL hold the shift register, bit counter and parity generator.
REQ-031 uart_tx top SHALL hold the FSM, the optional holding register and the output register.

Verification
REQ-032 Reset, then P_DATA=0xA5, PAR_EN=0, one-cycle DATA_VALID -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; busy high for exactly those 10 cycles.
REQ-033 P_DATA=0x0F, PAR_EN=1, PAR_TYP=0 -> parity bit 0; repeat with PAR_TYP=1 -> parity bit 1; 11-cycle frames.
REQ-034 Accept 0x3C, change P_DATA to 0xFF on the next cycle -> the serialized payload remains 0x3C.
REQ-035 Pulse rst low at data bit 4 -> TX_OUT goes 1 asynchronously, busy=0, and no stop or parity bit follows.
REQ-036 Loopback into uart_rx with PAR_EN=1 for 256 random words -> P_DATA matches and no parity or stop error.
REQ-037 With UART_TX_HOLD_BUF_EN, offer 0x11 then 0x22 two cycles later -> both frames sent with no idle cycle; a third word offered while the buffer is full is dropped. Without the macro, the second word is dropped.
